// File: rtl/intersection_phase_sched.sv
// intersection_phase_sched: timed phase scheduler/arbiter for the highway/country crossing.
// Highway owns the crossing by default; country, pedestrian and emergency requests borrow it.
module intersection_phase_sched #(
    parameter int MIN_GREEN = 8,
    parameter int MAX_CNTRY = 16,
    parameter int Y2RDELAY  = 3,
    parameter int R2GDELAY  = 2,
    parameter int WALK_TIME = 6,
    parameter int CW        = 5
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       cntry_req,
    input  logic       ped_req,
    input  logic       emerg_req,
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);
    typedef enum logic [2:0] {HG = 3'd0, HY = 3'd1, AR = 3'd2, CG = 3'd3, CY = 3'd4, PW = 3'd5} state_t;

    localparam logic [CW-1:0] T_MIN = CW'(MIN_GREEN - 1);
    localparam logic [CW-1:0] T_MAX = CW'(MAX_CNTRY - 1);
    localparam logic [CW-1:0] T_Y   = CW'(Y2RDELAY - 1);
    localparam logic [CW-1:0] T_R   = CW'(R2GDELAY - 1);
    localparam logic [CW-1:0] T_W   = CW'(WALK_TIME - 1);

    state_t        state, state_next, target, target_next;
    logic [CW-1:0] timer;
    logic          ped_pend, want_ped;

    always_comb begin
        state_next  = state;
        target_next = target;
        want_ped    = ped_pend | ped_req;
        case (state)
            HG: if (!emerg_req && timer >= T_MIN && (want_ped || cntry_req)) begin
                state_next  = HY;
                target_next = want_ped ? PW : CG;
            end
            HY: if (timer == T_Y) state_next = AR;
            AR: if (timer == T_R) state_next = emerg_req ? HG : target;
            CG: if (!cntry_req || emerg_req || timer == T_MAX) state_next = CY;
            CY: if (timer == T_Y) begin
                state_next  = AR;
                target_next = HG;
            end
            PW: if (timer == T_W) state_next = HG;
            default: state_next = HG;
        endcase
    end

    // ped_pend is cleared on PW entry, and button presses during PW are not latched
    always_ff @(posedge clock) begin
        if (clear) begin
            state    <= HG;
            target   <= HG;
            timer    <= '0;
            ped_pend <= 1'b0;
        end else begin
            state    <= state_next;
            target   <= target_next;
            timer    <= (state_next != state) ? '0 : (&timer ? timer : timer + CW'(1));
            ped_pend <= (state_next == PW && state != PW) ? 1'b0 :
                        (state != PW && ped_req) ? 1'b1 : ped_pend;
        end
    end

    always_comb begin
        hwy     = state == HG ? 2'd2 : state == HY ? 2'd1 : 2'd0;
        cntry   = state == CG ? 2'd2 : state == CY ? 2'd1 : 2'd0;
        walk    = state == PW;
        ped_ack = state == PW && timer == '0;
        phase   = state;
    end
endmodule
